// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - CPU memory port bridge: RAM passthrough plus UART TX FIFO / RX latch registers
module mmio_bridge #(
    parameter int addr_width      = 9,
    parameter int fifo_depth_log2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [addr_width-1:0] cpu_raddr,
    input  logic [addr_width-1:0] cpu_waddr,
    input  logic                  cpu_write,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic [addr_width-1:0] ram_raddr,
    output logic [addr_width-1:0] ram_waddr,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid
);

    localparam int pw    = fifo_depth_log2;
    localparam int cw    = fifo_depth_log2 + 1;
    localparam int depth = 2 ** fifo_depth_log2;

    localparam logic [pw-1:0] ptr_one    = {{(pw-1){1'b0}}, 1'b1};
    localparam logic [cw-1:0] cnt_one    = {{(cw-1){1'b0}}, 1'b1};
    localparam logic [cw-1:0] full_count = {1'b1, {(cw-1){1'b0}}};

    localparam logic [1:0] off_tx     = 2'd0;
    localparam logic [1:0] off_rx     = 2'd1;
    localparam logic [1:0] off_status = 2'd2;
    localparam logic [1:0] off_count  = 2'd3;

    logic [7:0]    mem_q [depth];
    logic [pw-1:0] wptr_q, wptr_d;
    logic [pw-1:0] rptr_q, rptr_d;
    logic [cw-1:0] count_q, count_d;

    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_avail_q, rx_avail_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       tx_overflow_q, tx_overflow_d;

    logic       rd_io_q;
    logic [7:0] io_byte_q, io_byte_d;

    logic io_w, io_r;
    logic wr_tx, wr_rx_ack, wr_count;
    logic tx_full, tx_empty;
    logic push_ok, push_drop, pop;
    logic rx_take, rx_drop;

    assign io_w = &cpu_waddr[addr_width-1:2];
    assign io_r = &cpu_raddr[addr_width-1:2];

    assign ram_raddr = cpu_raddr;
    assign ram_waddr = cpu_waddr;
    assign ram_wdata = cpu_wdata;
    assign ram_we    = cpu_write & ~io_w;

    assign wr_tx     = cpu_write & io_w & (cpu_waddr[1:0] == off_tx);
    assign wr_rx_ack = cpu_write & io_w & (cpu_waddr[1:0] == off_rx);
    assign wr_count  = cpu_write & io_w & (cpu_waddr[1:0] == off_count);

    // Full is judged before this cycle's pop, so a push into a full FIFO drops even if a pop frees a slot.
    assign tx_full   = (count_q == full_count);
    assign tx_empty  = (count_q == '0);
    assign tx_valid  = ~tx_empty;
    assign tx_data   = mem_q[rptr_q];
    assign pop       = tx_valid & tx_ready;
    assign push_ok   = wr_tx & ~tx_full;
    assign push_drop = wr_tx & tx_full;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) wptr_d = wptr_q + ptr_one;
        if (pop)     rptr_d = rptr_q + ptr_one;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + cnt_one;
            2'b01:   count_d = count_q - cnt_one;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= cpu_wdata;
    end

    // An ack in the same cycle as a new byte frees the latch for it, so that byte is not an overrun.
    assign rx_take = rx_valid & (~rx_avail_q | wr_rx_ack);
    assign rx_drop = rx_valid & rx_avail_q & ~wr_rx_ack;

    always_comb begin
        rx_byte_d  = rx_byte_q;
        rx_avail_d = rx_avail_q;
        if (rx_take) begin
            rx_byte_d  = rx_data;
            rx_avail_d = 1'b1;
        end else if (wr_rx_ack) begin
            rx_avail_d = 1'b0;
        end
        rx_overrun_d  = (rx_overrun_q & ~wr_count) | rx_drop;
        tx_overflow_d = (tx_overflow_q & ~wr_count) | push_drop;
    end

    always_comb begin
        io_byte_d = 8'h00;
        case (cpu_raddr[1:0])
            off_tx:     io_byte_d = 8'h00;
            off_rx:     io_byte_d = rx_byte_q;
            off_status: io_byte_d = {3'b000, tx_overflow_q, rx_overrun_q, rx_avail_q, tx_empty, tx_full};
            off_count:  io_byte_d = {{(8-cw){1'b0}}, count_q};
            default:    io_byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            rx_byte_q     <= 8'h00;
            rx_avail_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_overflow_q <= 1'b0;
            rd_io_q       <= 1'b0;
            io_byte_q     <= 8'h00;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            rx_byte_q     <= rx_byte_d;
            rx_avail_q    <= rx_avail_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_overflow_q <= tx_overflow_d;
            rd_io_q       <= io_r;
            io_byte_q     <= io_byte_d;
        end
    end

    assign cpu_rdata = rd_io_q ? io_byte_q : ram_rdata;

endmodule
